uart_rx_os16: RTL and testbench

//   Oversampling UART receiver: recovers 8N1 (optional parity) frames from the serial line into parallel bytes.
//   It is the receive end of the serial link that the UART transmitter drives; uart_top instantiates it on the rx pin.

---
 rtl/uart_rx_os16.sv | 153 +++++++++++++++
 tb/tb_uart_rx_os16.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver (8 data bits, optional parity, 1 stop bit).
// Each bit is decided by a majority vote of samples 7, 8 and 9; framing and parity errors are flagged per frame.
module uart_rx_os16 #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       valid_rx,
  output logic       stop_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR_BIT,
    STOP
  } state_t;

  state_t state_reg, state_next;

  logic          rx_meta_reg, rx_s_reg, rx_s_d_reg;
  logic [1:0]    fill_reg;
  logic          armed_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [3:0]    s_reg;
  logic          s7_reg, s8_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          par_mismatch_reg;
  logic [7:0]    rx_data_reg;
  logic          valid_rx_reg, stop_error_reg, parity_error_reg;

  logic tick, decide, maj, start_det, frame_done;

  assign tick       = (tick_cnt_reg == TICK_LAST);
  assign decide     = tick && (s_reg == 4'd9) && (state_reg != IDLE);
  assign maj        = (s7_reg & s8_reg) | (s7_reg & rx_s_reg) | (s8_reg & rx_s_reg);
  assign start_det  = (state_reg == IDLE) && armed_reg && rx_s_d_reg && !rx_s_reg;
  assign frame_done = (state_reg == STOP) && decide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_det) state_next = START;
      end
      START: begin
        // A high majority means the falling edge was a glitch.
        if (decide) state_next = maj ? IDLE : DATA;
      end
      DATA: begin
        if (decide && (bit_cnt_reg == 3'd7)) state_next = (PARITY != 0) ? PAR_BIT : STOP;
      end
      PAR_BIT: begin
        if (decide) state_next = STOP;
      end
      STOP: begin
        if (decide) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Synchroniser, arming and sample timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg  <= 1'b1;
      rx_s_reg     <= 1'b1;
      rx_s_d_reg   <= 1'b1;
      fill_reg     <= 2'd0;
      armed_reg    <= 1'b0;
      tick_cnt_reg <= '0;
      s_reg        <= 4'd0;
      s7_reg       <= 1'b1;
      s8_reg       <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
      rx_s_d_reg  <= rx_s_reg;
      if (fill_reg != 2'd2) fill_reg <= fill_reg + 2'd1;
      // Arm only on a high level that really came through the synchroniser, not its reset value.
      if (frame_done && !maj) armed_reg <= 1'b0;
      else if ((fill_reg == 2'd2) && rx_s_reg) armed_reg <= 1'b1;

      if (state_reg == IDLE) tick_cnt_reg <= '0;
      else if (tick) tick_cnt_reg <= '0;
      else tick_cnt_reg <= tick_cnt_reg + TW'(1);

      if (state_reg == IDLE) s_reg <= 4'd0;
      else if (tick) s_reg <= s_reg + 4'd1;

      if (tick && (s_reg == 4'd7)) s7_reg <= rx_s_reg;
      if (tick && (s_reg == 4'd8)) s8_reg <= rx_s_reg;
    end
  end

  // Data capture, parity and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg      <= 3'd0;
      shift_reg        <= 8'h00;
      par_mismatch_reg <= 1'b0;
      rx_data_reg      <= 8'h00;
      valid_rx_reg     <= 1'b0;
      stop_error_reg   <= 1'b0;
      parity_error_reg <= 1'b0;
    end else begin
      valid_rx_reg <= frame_done;
      if (start_det) begin
        bit_cnt_reg <= 3'd0;
      end else if ((state_reg == DATA) && decide) begin
        shift_reg   <= {maj, shift_reg[7:1]};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
      if ((state_reg == PAR_BIT) && decide) begin
        if (PARITY == 1) par_mismatch_reg <= ~(^shift_reg ^ maj);
        else             par_mismatch_reg <= ^shift_reg ^ maj;
      end
      if (frame_done) begin
        rx_data_reg      <= shift_reg;
        stop_error_reg   <= ~maj;
        parity_error_reg <= (PARITY != 0) ? par_mismatch_reg : 1'b0;
      end
    end
  end

  assign rx_data      = rx_data_reg;
  assign valid_rx     = valid_rx_reg;
  assign stop_error   = stop_error_reg;
  assign parity_error = parity_error_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16: one DUT without parity, one with even parity.
// Stimulus pushes expected frames; a monitor pops and compares on every valid_rx pulse.
module tb_uart_rx_os16;
  localparam int CLK_FREQ = 7_372_800;
  localparam int BAUD     = 115200;
  localparam int DIV      = 4;
  localparam int BIT      = 16 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line = 1'b1;
  logic sel = 1'b0;
  logic rx_a, rx_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic valid_rx_a, valid_rx_b, stop_error_a, stop_error_b;
  logic parity_error_a, parity_error_b, busy_a, busy_b;

  assign rx_a = sel ? 1'b1 : line;
  assign rx_b = sel ? line : 1'b1;

  always #5 clk = ~clk;

  uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .PARITY(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(rx_data_a), .valid_rx(valid_rx_a),
    .stop_error(stop_error_a), .parity_error(parity_error_a), .busy(busy_a));

  uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .PARITY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(rx_data_b), .valid_rx(valid_rx_b),
    .stop_error(stop_error_b), .parity_error(parity_error_b), .busy(busy_b));

  typedef struct packed {
    logic [7:0] data;
    logic       stop_err;
    logic       par_err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (valid_rx_a) begin
      if (q_a.size() == 0) begin
        check("unexpected_frame_a", {24'h0, rx_data_a}, 32'hFFFF_FFFF);
      end else begin
        ea = q_a.pop_front();
        $display("[%0t] dut_a frame: data=%02h stop_err=%0b par_err=%0b", $time,
                 rx_data_a, stop_error_a, parity_error_a);
        check("rx_data_a", {24'h0, rx_data_a}, {24'h0, ea.data});
        check("stop_error_a", {31'h0, stop_error_a}, {31'h0, ea.stop_err});
        check("parity_error_a", {31'h0, parity_error_a}, {31'h0, ea.par_err});
      end
    end
    if (valid_rx_b) begin
      if (q_b.size() == 0) begin
        check("unexpected_frame_b", {24'h0, rx_data_b}, 32'hFFFF_FFFF);
      end else begin
        eb = q_b.pop_front();
        $display("[%0t] dut_b frame: data=%02h stop_err=%0b par_err=%0b", $time,
                 rx_data_b, stop_error_b, parity_error_b);
        check("rx_data_b", {24'h0, rx_data_b}, {24'h0, eb.data});
        check("stop_error_b", {31'h0, stop_error_b}, {31'h0, eb.stop_err});
        check("parity_error_b", {31'h0, parity_error_b}, {31'h0, eb.par_err});
      end
    end
  end

  task automatic hold(input logic v, input int n);
    line = v;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame; glitch_bit >= 0 inverts that data bit for 8 clks well before its sample points.
  task automatic send(input logic [7:0] d, input logic stop, input bit use_par, input logic pbit,
                      input int glitch_bit);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        hold(d[i], 4);
        hold(~d[i], 8);
        hold(d[i], BIT - 12);
      end else begin
        hold(d[i], BIT);
      end
    end
    if (use_par) hold(pbit, BIT);
    hold(stop, BIT);
  endtask

  task automatic frame_a(input logic [7:0] d, input logic stop, input int glitch_bit);
    q_a.push_back('{data: d, stop_err: ~stop, par_err: 1'b0});
    send(d, stop, 1'b0, 1'b0, glitch_bit);
  endtask

  task automatic frame_b(input logic [7:0] d, input logic pbit, input logic exp_pe);
    q_b.push_back('{data: d, stop_err: 1'b0, par_err: exp_pe});
    send(d, 1'b1, 1'b1, pbit, -1);
  endtask

  task automatic drain();
    int t = 0;
    while (((q_a.size() + q_b.size()) != 0) && (t < 20 * BIT)) begin
      @(negedge clk);
      t++;
    end
    check("pending_frames", q_a.size() + q_b.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'h0, rx_data_a}, 32'h0);
    check("reset_valid", {31'h0, valid_rx_a}, 32'h0);
    check("reset_busy", {31'h0, busy_a}, 32'h0);
    check("reset_stop_error", {31'h0, stop_error_a}, 32'h0);
    rst_n = 1'b1;
    hold(1'b1, 2 * BIT);

    // Single frame with a busy check in the middle.
    fork
      frame_a(8'hA5, 1'b1, -1);
      begin
        repeat (5 * BIT) @(negedge clk);
        check("busy_mid_frame", {31'h0, busy_a}, 32'h1);
      end
    join
    hold(1'b1, BIT);

    // Back-to-back frames, no idle gap.
    frame_a(8'h00, 1'b1, -1);
    frame_a(8'hFF, 1'b1, -1);
    frame_a(8'h55, 1'b1, -1);
    frame_a(8'h3C, 1'b1, -1);
    hold(1'b1, BIT);

    // Framing error followed by a good frame.
    frame_a(8'h81, 1'b0, -1);
    hold(1'b1, BIT);
    frame_a(8'h42, 1'b1, -1);
    hold(1'b1, BIT);

    // Short glitch on the idle line must not produce a frame.
    hold(1'b0, 3);
    hold(1'b1, 2 * BIT);
    check("busy_after_glitch", {31'h0, busy_a}, 32'h0);

    // Glitch inside data bit 3, away from the sample points.
    frame_a(8'h96, 1'b1, 3);
    hold(1'b1, BIT);

    // Break: one frame of zeros with a stop error, then nothing while low.
    q_a.push_back('{data: 8'h00, stop_err: 1'b1, par_err: 1'b0});
    hold(1'b0, 14 * BIT);
    check("busy_during_break", {31'h0, busy_a}, 32'h0);
    hold(1'b1, 2 * BIT);
    drain();

    // Even parity on the second receiver.
    sel = 1'b1;
    hold(1'b1, BIT);
    frame_b(8'h07, 1'b1, 1'b0);
    frame_b(8'h07, 1'b0, 1'b1);
    hold(1'b1, BIT);
    sel = 1'b0;
    hold(1'b1, BIT);
    drain();

    // Reset in the middle of bit 4 of a 0x3C frame.
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(1'b0 ^ ((8'h3C >> i) & 1), BIT);
    hold(1'b1, BIT / 2);
    rst_n = 1'b0;
    #1;
    check("midreset_rx_data", {24'h0, rx_data_a}, 32'h0);
    check("midreset_valid", {31'h0, valid_rx_a}, 32'h0);
    check("midreset_stop_error", {31'h0, stop_error_a}, 32'h0);
    check("midreset_busy", {31'h0, busy_a}, 32'h0);
    check("midreset_parity_error_b", {31'h0, parity_error_b}, 32'h0);
    hold(1'b1, 3);
    rst_n = 1'b1;
    hold(1'b1, 2 * BIT);
    frame_a(8'h3C, 1'b1, -1);
    hold(1'b1, BIT);
    drain();

    // Line held low through reset release: no frame until it goes high.
    line = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    hold(1'b0, 4);
    rst_n = 1'b1;
    hold(1'b0, 20 * BIT);
    check("busy_low_after_reset", {31'h0, busy_a}, 32'h0);
    hold(1'b1, 2 * BIT);
    frame_a(8'h5A, 1'b1, -1);
    hold(1'b1, BIT);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
